// File: rtl/test_monitor_if.sv
// ============================================================================
// Module   : test_monitor_if
// Brief    : Core trace inputs and test-result outputs of the test monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface test_monitor_if;
  logic [31:0] pc;
  logic        pc_valid;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [30:0] test_num;
  logic [31:0] cycles;

  // Core/trace side: drives the trace, observes the verdict.
  modport master (
    output pc, pc_valid, rd_we, rd_addr, rd_data,
    input  done, pass, fail, timeout, test_num, cycles
  );

  // Monitor side.
  modport slave (
    input  pc, pc_valid, rd_we, rd_addr, rd_data,
    output done, pass, fail, timeout, test_num, cycles
  );
endinterface

`default_nettype wire

// File: rtl/test_monitor.sv
// ============================================================================
// Module   : test_monitor
// Brief    : Watches core PC and gp writes; reports pass/fail/timeout verdict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_monitor #(
  parameter logic [31:0] END_PC = 32'h0000_0044,
  parameter int unsigned TICKS  = 5000,
  parameter logic [4:0]  GP_REG = 5'd3
) (
  input  logic           clk,
  input  logic           rst,
  test_monitor_if.slave  mon
);

  localparam logic [31:0] c_tick_last = 32'(TICKS) - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [31:0] r_gp,       w_gp_nxt;
  logic [31:0] r_cycles,   w_cycles_nxt;
  logic        r_done,     w_done_nxt;
  logic        r_pass,     w_pass_nxt;
  logic        r_fail,     w_fail_nxt;
  logic        r_timeout,  w_timeout_nxt;
  logic [30:0] r_test_num, w_test_num_nxt;

  logic        w_gp_wr;
  logic [31:0] w_gp_eval;
  logic        w_end_hit;

  // x0 is hardwired in the core, so a write to index 0 never reaches gp.
  assign w_gp_wr   = mon.rd_we && (mon.rd_addr == GP_REG) && (mon.rd_addr != 5'd0);
  assign w_gp_eval = w_gp_wr ? mon.rd_data : r_gp;
  assign w_end_hit = mon.pc_valid && (mon.pc == END_PC);

  always_comb begin
    w_state_nxt    = r_state;
    w_gp_nxt       = r_gp;
    w_cycles_nxt   = r_cycles;
    w_done_nxt     = r_done;
    w_pass_nxt     = r_pass;
    w_fail_nxt     = r_fail;
    w_timeout_nxt  = r_timeout;
    w_test_num_nxt = r_test_num;

    if (r_state != S_DONE && w_gp_wr) begin
      w_gp_nxt = mon.rd_data;
    end

    case (r_state)
      S_IDLE: begin
        w_cycles_nxt = '0;
        if (mon.pc_valid) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cycles_nxt = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;
        // End detection takes priority over a coincident watchdog expiry.
        if (w_end_hit) begin
          w_state_nxt    = S_DONE;
          w_done_nxt     = 1'b1;
          w_pass_nxt     = (w_gp_eval == 32'h1);
          w_fail_nxt     = (w_gp_eval != 32'h1);
          w_test_num_nxt = w_gp_eval[31:1];
        end else if (r_cycles == c_tick_last) begin
          w_state_nxt    = S_DONE;
          w_done_nxt     = 1'b1;
          w_timeout_nxt  = 1'b1;
        end
      end
      S_DONE: begin
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_gp       <= '0;
      r_cycles   <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
      r_test_num <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gp       <= w_gp_nxt;
      r_cycles   <= w_cycles_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_fail     <= w_fail_nxt;
      r_timeout  <= w_timeout_nxt;
      r_test_num <= w_test_num_nxt;
    end
  end

  assign mon.done     = r_done;
  assign mon.pass     = r_pass;
  assign mon.fail     = r_fail;
  assign mon.timeout  = r_timeout;
  assign mon.test_num = r_test_num;
  assign mon.cycles   = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_test_monitor.sv
// ============================================================================
// Module   : tb_test_monitor
// Brief    : Scoreboard bench for test_monitor verdicts, latency and stickiness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test_monitor;

  localparam int unsigned c_ticks  = 5000;
  localparam logic [31:0] c_end_pc = 32'h0000_0044;

  typedef struct {
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] test_num;
    logic [31:0] cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  test_monitor_if mon_if ();

  test_monitor #(
    .END_PC (c_end_pc),
    .TICKS  (c_ticks),
    .GP_REG (5'd3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   mon_cnt;
  logic prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string pfx, input exp_t e);
    check_eq({pfx, "_done"},     64'(mon_if.done),     64'(e.done));
    check_eq({pfx, "_pass"},     64'(mon_if.pass),     64'(e.pass));
    check_eq({pfx, "_fail"},     64'(mon_if.fail),     64'(e.fail));
    check_eq({pfx, "_timeout"},  64'(mon_if.timeout),  64'(e.timeout));
    check_eq({pfx, "_test_num"}, 64'(mon_if.test_num), 64'(e.test_num));
    check_eq({pfx, "_cycles"},   64'(mon_if.cycles),   64'(e.cycles));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mon_if.pc_valid = 1'b0;
    mon_if.pc       = '0;
    mon_if.rd_we    = 1'b0;
    mon_if.rd_addr  = '0;
    mon_if.rd_data  = '0;
  endtask

  task automatic do_reset();
    exp_t z;
    z = '{done: 1'b0, pass: 1'b0, fail: 1'b0, timeout: 1'b0, test_num: '0, cycles: '0};
    rst = 1'b0;
    drive_idle();
    step();
    check_outputs("rst", z);
    rst = 1'b1;
  endtask

  // Enter RUN (optionally loading gp), run end_cyc cycles, then end or let the
  // watchdog fire (end_cyc < 0). pre_gp is the shadow value expected at the end.
  task automatic run_case(input bit pre_wr, input logic [31:0] pre_gp, input int end_cyc,
                          input bit wr_same, input logic [4:0] wr_addr,
                          input logic [31:0] wr_data);
    exp_t        e;
    logic [31:0] gp_eval;
    int          k;
    mon_if.pc_valid = 1'b1;
    mon_if.pc       = 32'h100;
    mon_if.rd_we    = pre_wr;
    mon_if.rd_addr  = 5'd3;
    mon_if.rd_data  = pre_gp;
    step();
    drive_idle();
    check_eq("entry_cycles", 64'(mon_if.cycles), 64'd0);
    if (end_cyc >= 0) begin
      for (int i = 0; i < end_cyc; i++) begin
        mon_if.pc_valid = ((i % 3) != 0);
        mon_if.pc       = 32'h100 + 32'(4 * i);
        mon_if.rd_we    = ((i % 5) == 2);
        mon_if.rd_addr  = 5'd4;
        mon_if.rd_data  = 32'h1;
        step();
      end
      check_eq("pre_end_done",   64'(mon_if.done),   64'd0);
      check_eq("pre_end_cycles", 64'(mon_if.cycles), 64'(end_cyc));
      gp_eval    = (wr_same && wr_addr == 5'd3) ? wr_data : pre_gp;
      e.done     = 1'b1;
      e.pass     = (gp_eval == 32'h1);
      e.fail     = (gp_eval != 32'h1);
      e.timeout  = 1'b0;
      e.test_num = gp_eval[31:1];
      e.cycles   = 32'(end_cyc + 1);
      sb_q.push_back(e);
      last_exp = e;
      mon_if.pc_valid = 1'b1;
      mon_if.pc       = c_end_pc;
      mon_if.rd_we    = wr_same;
      mon_if.rd_addr  = wr_addr;
      mon_if.rd_data  = wr_data;
      step();
      drive_idle();
    end else begin
      e = '{done: 1'b1, pass: 1'b0, fail: 1'b0, timeout: 1'b1, test_num: '0, cycles: 32'(c_ticks)};
      sb_q.push_back(e);
      last_exp = e;
      k = 0;
      while (!mon_if.done && k < int'(c_ticks) + 10) begin
        mon_if.pc_valid = 1'($urandom % 2);
        mon_if.pc       = $urandom | 32'h100;
        step();
        k++;
      end
      drive_idle();
      check_eq("wdog_edges", 64'(k), 64'(c_ticks));
    end
    check_eq("done_seen", 64'(mon_if.done), 64'd1);
    for (int i = 0; i < 3; i++) begin
      mon_if.pc_valid = 1'b1;
      mon_if.pc       = c_end_pc;
      mon_if.rd_we    = 1'b1;
      mon_if.rd_addr  = 5'd3;
      mon_if.rd_data  = ~pre_gp;
      step();
      check_outputs("sticky", last_exp);
    end
    drive_idle();
  endtask

  // Scoreboard consumer plus the pass/fail/timeout exclusivity check.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    mon_cnt = int'(mon_if.pass) + int'(mon_if.fail) + int'(mon_if.timeout);
    check_eq("verdict_onehot", 64'(mon_cnt), 64'(mon_if.done));
    if (mon_if.done && !prev_done) begin
      check_eq("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_outputs("sb", e);
      end
    end
    prev_done = mon_if.done;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    drive_idle();

    do_reset();
    run_case(1'b1, 32'h1, 100, 1'b0, 5'd0, 32'h0);
    check_eq("pass_cycles_101", 64'(mon_if.cycles), 64'd101);

    do_reset();
    run_case(1'b1, 32'h7, 20, 1'b0, 5'd0, 32'h0);
    check_eq("fail_test_num_3", 64'(mon_if.test_num), 64'd3);

    do_reset();
    run_case(1'b1, 32'h5, 30, 1'b1, 5'd3, 32'h1);
    check_eq("fwd_gp_pass", 64'(mon_if.pass), 64'd1);

    do_reset();
    run_case(1'b1, 32'h5, 30, 1'b1, 5'd0, 32'h1);
    check_eq("x0_write_fail", 64'(mon_if.fail), 64'd1);

    do_reset();
    run_case(1'b1, 32'h1, -1, 1'b0, 5'd0, 32'h0);
    check_eq("timeout_cycles", 64'(mon_if.cycles), 64'd5000);

    do_reset();
    run_case(1'b1, 32'h8000_0001, 5, 1'b0, 5'd0, 32'h0);

    do_reset();
    run_case(1'b1, 32'h1, int'(c_ticks) - 1, 1'b0, 5'd0, 32'h0);
    check_eq("end_beats_wdog", 64'(mon_if.timeout), 64'd0);

    // Reset in DONE clears everything; then reset mid-RUN beats end + gp write.
    do_reset();
    mon_if.pc_valid = 1'b1;
    mon_if.pc       = 32'h100;
    step();
    drive_idle();
    for (int i = 0; i < 10; i++) step();
    check_eq("midrun_cycles", 64'(mon_if.cycles), 64'd10);
    rst             = 1'b0;
    mon_if.pc_valid = 1'b1;
    mon_if.pc       = c_end_pc;
    mon_if.rd_we    = 1'b1;
    mon_if.rd_addr  = 5'd3;
    mon_if.rd_data  = 32'h1;
    step();
    check_eq("rst_wins_done",   64'(mon_if.done),   64'd0);
    check_eq("rst_wins_cycles", 64'(mon_if.cycles), 64'd0);
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 3; i++) step();
    check_eq("idle_cycles_hold", 64'(mon_if.cycles), 64'd0);
    check_eq("idle_done_low",    64'(mon_if.done),   64'd0);
    run_case(1'b0, 32'h0, 4, 1'b0, 5'd0, 32'h0);

    step();
    step();
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
